// File: rtl/hollywood_hash_feeder_if.sv
// rtl/hollywood_hash_feeder_if.sv - channelized 16-bit password stream into the hollywood hash core
interface hollywood_hash_feeder_if;
  logic        out_valid;
  logic        out_channel;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (output out_valid, output out_channel, output out_data, input out_ready);
  modport slave  (input out_valid, input out_channel, input out_data, output out_ready);
endinterface

// File: rtl/hollywood_hash_feeder.sv
// rtl/hollywood_hash_feeder.sv - candidate password generator feeding the hash core and watching its hit flag
module hollywood_hash_feeder #(
  parameter int WORDS        = 2,
  parameter int RESULT_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WORDS*16-1:0]   start_value,
  input  logic                  stop,
  hollywood_hash_feeder_if.master stream,
  input  logic                  hit_in,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WORDS*16-1:0]   found_data
);
  localparam int CW    = WORDS * 16;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(RESULT_DELAY + 1);

  typedef enum logic [1:0] {IDLE, MGMT, DATA, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cand_q, cand_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             stop_req_q, stop_req_d;
  logic             valid_q, valid_d;
  logic             chan_q, chan_d;
  logic [15:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [CW-1:0]    fdata_q, fdata_d;
  logic             hs;

  assign hs = valid_q & stream.out_ready;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    stop_req_d = stop_req_q;
    found_d    = found_q;
    fdata_d    = fdata_q;
    done_d     = 1'b0;
    valid_d    = 1'b0;
    chan_d     = 1'b0;
    data_d     = 16'h0000;

    case (state_q)
      IDLE: begin
        if (start) begin
          cand_d     = start_value;
          found_d    = 1'b0;
          fdata_d    = '0;
          stop_req_d = 1'b0;
          state_d    = MGMT;
        end
      end
      MGMT: begin
        if (hs) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (hs) begin
          if (idx_q == IDX_W'(WORDS - 1)) begin
            wcnt_d  = CNT_W'(1);
            state_d = WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // hit_in only means something in this one cycle; the core may glitch it elsewhere
        if (wcnt_q == CNT_W'(RESULT_DELAY)) begin
          if (hit_in) begin
            found_d = 1'b1;
            fdata_d = cand_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if ((&cand_q) || stop_req_q || stop) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cand_d  = cand_q + 1'b1;
            state_d = MGMT;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && stop) stop_req_d = 1'b1;

    // Beat fields are derived from the next state so every output leaves a flop
    valid_d = (state_d == MGMT) || (state_d == DATA);
    chan_d  = (state_d == MGMT);
    if (state_d == DATA) begin
      for (int i = 0; i < WORDS; i++) begin
        if (idx_d == IDX_W'(i)) data_d = cand_d[(WORDS-1-i)*16 +: 16];
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      stop_req_q <= 1'b0;
      valid_q    <= 1'b0;
      chan_q     <= 1'b0;
      data_q     <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      fdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      stop_req_q <= stop_req_d;
      valid_q    <= valid_d;
      chan_q     <= chan_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      fdata_q    <= fdata_d;
    end
  end

  assign stream.out_valid   = valid_q;
  assign stream.out_channel = chan_q;
  assign stream.out_data    = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign found_data = fdata_q;
endmodule

// File: tb/tb_hollywood_hash_feeder.sv
// tb/tb_hollywood_hash_feeder.sv - directed bench for hollywood_hash_feeder with a two-word core model
module tb_hollywood_hash_feeder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] start_value = 32'h0;
  logic        hit_in;
  logic        busy, done, found;
  logic [31:0] found_data;

  int checks = 0;
  int failures = 0;

  hollywood_hash_feeder_if sif ();

  hollywood_hash_feeder #(.WORDS(2), .RESULT_DELAY(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_value(start_value),
    .stop       (stop),
    .stream     (sif.master),
    .hit_in     (hit_in),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .found_data (found_data)
  );

  always #5 clk = ~clk;

  // Ready source: constant 1 or coin flip, changed mid-cycle
  logic rand_ready = 1'b0;
  always @(negedge clk) sif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Core model: MGMT clears, hit rises after the second data word if it matches target
  logic [31:0] target = 32'h0BAD_0BAD;
  logic [15:0] hi_word = 16'h0;
  logic        nw = 1'b0;
  logic        core_hit = 1'b0;
  logic        force_hit = 1'b0;
  logic [16:0] beats[$];
  assign hit_in = core_hit | force_hit;

  always @(posedge clk) begin
    if (sif.out_valid && sif.out_ready) begin
      beats.push_back({sif.out_channel, sif.out_data});
      if (sif.out_channel) begin
        nw       <= 1'b0;
        core_hit <= 1'b0;
      end else if (!nw) begin
        hi_word <= sif.out_data;
        nw      <= 1'b1;
      end else begin
        core_hit <= ({hi_word, sif.out_data} == target);
      end
    end
  end

  // Stream stability watcher
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_beat = 17'h0;
  always @(posedge clk) begin
    if (prev_stall && reset_n && (sif.out_valid !== 1'b1 || {sif.out_channel, sif.out_data} !== prev_beat))
      stall_err = stall_err + 1;
    prev_stall <= reset_n && sif.out_valid && !sif.out_ready;
    prev_beat  <= {sif.out_channel, sif.out_data};
  end

  logic        first_busy;
  logic [17:0] first_beat;

  // force_mode: 0 none, 1 high except sampling cycles (5k), 2 high only in cycle force_cyc
  task automatic do_run(input logic [31:0] sv, input int force_mode, input int force_cyc,
                        input int stop_cyc, input int bound, output int cycles);
    beats.delete();
    @(negedge clk);
    start_value = sv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    first_busy = busy;
    first_beat = {sif.out_valid, sif.out_channel, sif.out_data};
    forever begin
      force_hit = (force_mode == 1) ? ((cycles % 5) != 0) : (force_mode == 2) ? (cycles == force_cyc) : 1'b0;
      stop = (cycles == stop_cyc);
      if (done) break;
      if (cycles >= bound) begin
        cycles = -1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    force_hit = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sif.out_valid, sif.out_channel, sif.out_data} !== 18'h0) begin
      $display("FAIL reset_stream got=%h exp=0", {sif.out_valid, sif.out_channel, sif.out_data});
      failures++;
    end
    checks++;
    if ({busy, done, found, found_data} !== 35'h0) begin
      $display("FAIL reset_status got=%h exp=0", {busy, done, found, found_data});
      failures++;
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hit_search();
    int cyc;
    target = 32'h0000_1234;
    do_run(32'h0000_1200, 0, 0, 0, 1000, cyc);
    checks++;
    if (first_busy !== 1'b1 || first_beat !== 18'h3_0000) begin
      $display("FAIL first_mgmt busy=%b beat=%h exp busy=1 beat=30000", first_busy, first_beat);
      failures++;
    end
    checks++;
    if (cyc != 266) begin
      $display("FAIL hit_latency got=%0d exp=266", cyc);
      failures++;
    end
    checks++;
    if (found !== 1'b1 || found_data !== 32'h0000_1234 || busy !== 1'b0) begin
      $display("FAIL hit_result found=%b data=%h busy=%b exp 1 00001234 0", found, found_data, busy);
      failures++;
    end
    checks++;
    if (beats.size() != 159 || beats[0] !== 17'h1_0000 || beats[1] !== 17'h0_0000 || beats[2] !== 17'h0_1200) begin
      $display("FAIL hit_beats size=%0d exp=159", beats.size());
      failures++;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || found !== 1'b1) begin
      $display("FAIL done_pulse done=%b found=%b exp 0 1", done, found);
      failures++;
    end
  endtask

  task automatic test_exhaust();
    int cyc;
    logic [16:0] exp_q[$];
    exp_q = '{17'h1_0000, 17'h0_FFFF, 17'h0_FFFE, 17'h1_0000, 17'h0_FFFF, 17'h0_FFFF};
    target = 32'h0BAD_0BAD;
    do_run(32'hFFFF_FFFE, 0, 0, 0, 100, cyc);
    checks++;
    if (cyc != 11 || found !== 1'b0) begin
      $display("FAIL exhaust_done cycles=%0d found=%b exp 11 0", cyc, found);
      failures++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (beats != exp_q || busy !== 1'b0) begin
      $display("FAIL exhaust_beats size=%0d busy=%b exp size=6 busy=0", beats.size(), busy);
      failures++;
    end
  endtask

  task automatic test_random_ready();
    int cyc;
    int bad = 0;
    target = 32'h0000_1234;
    stall_err = 0;
    rand_ready = 1'b1;
    do_run(32'h0000_1200, 0, 0, 0, 4000, cyc);
    rand_ready = 1'b0;
    if (beats.size() != 159) bad = 1;
    else
      for (int k = 0; k < 53; k++)
        if (beats[3*k] !== 17'h1_0000 || beats[3*k+1] !== 17'h0_0000 || beats[3*k+2] !== {1'b0, 16'h1200 + 16'(k)})
          bad = 1;
    checks++;
    if (bad != 0 || cyc < 266) begin
      $display("FAIL rr_beats size=%0d cycles=%0d exp size=159 cycles>=266", beats.size(), cyc);
      failures++;
    end
    checks++;
    if (stall_err != 0) begin
      $display("FAIL rr_stability got=%0d exp=0", stall_err);
      failures++;
    end
    checks++;
    if (found !== 1'b1 || found_data !== 32'h0000_1234) begin
      $display("FAIL rr_found found=%b data=%h exp 1 00001234", found, found_data);
      failures++;
    end
  endtask

  task automatic test_spurious_hit();
    int cyc;
    target = 32'h0BAD_0BAD;
    do_run(32'hFFFF_FFF0, 1, 0, 0, 200, cyc);
    checks++;
    if (cyc != 81 || found !== 1'b0) begin
      $display("FAIL spurious_ignored cycles=%0d found=%b exp 81 0", cyc, found);
      failures++;
    end
    do_run(32'hFFFF_FFF0, 2, 20, 0, 200, cyc);
    checks++;
    if (cyc != 21 || found !== 1'b1 || found_data !== 32'hFFFF_FFF3) begin
      $display("FAIL sample_hit cycles=%0d found=%b data=%h exp 21 1 fffffff3", cyc, found, found_data);
      failures++;
    end
  endtask

  task automatic test_stop();
    int cyc;
    int n;
    target = 32'h0BAD_0BAD;
    do_run(32'h0000_0100, 0, 0, 27, 200, cyc);
    checks++;
    if (cyc != 31 || found !== 1'b0) begin
      $display("FAIL stop_done cycles=%0d found=%b exp 31 0", cyc, found);
      failures++;
    end
    checks++;
    if (beats.size() != 18 || beats[17] !== 17'h0_0105) begin
      $display("FAIL stop_beats size=%0d exp=18", beats.size());
      failures++;
    end
    start_value = 32'h0000_0200;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || {sif.out_valid, sif.out_channel, sif.out_data} !== 18'h3_0000) begin
      $display("FAIL stop_restart busy=%b beat=%h exp 1 30000", busy, {sif.out_valid, sif.out_channel, sif.out_data});
      failures++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL stop_second_run done=%b exp=1 (timeout)", done);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_value = 32'hABCD_0055;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({sif.out_valid, sif.out_channel, sif.out_data} !== 18'h2_ABCD) begin
      $display("FAIL mid_data_beat got=%h exp=2abcd", {sif.out_valid, sif.out_channel, sif.out_data});
      failures++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({sif.out_valid, sif.out_channel, sif.out_data, busy, done, found} !== 21'h0) begin
      $display("FAIL async_reset got=%h exp=0", {sif.out_valid, sif.out_channel, sif.out_data, busy, done, found});
      failures++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_value = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || {sif.out_valid, sif.out_channel, sif.out_data} !== 18'h3_0000) begin
      $display("FAIL post_reset_start busy=%b beat=%h exp 1 30000", busy, {sif.out_valid, sif.out_channel, sif.out_data});
      failures++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hit_search();
    test_exhaust();
    test_random_ready();
    test_spurious_hit();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hollywood_hash_feeder.md
# hollywood_hash_feeder

Password-candidate generator that drives the hollywood hash core's password input stream and watches its success flag. It works through a range of candidate passwords. For each candidate it sends one management word, which clears the core's hash state, then WORDS data words. It samples the core's success flag at a fixed latency after the last word, and stops on the first hit or when the candidate space is exhausted. It sits between the control/status logic and the hash core, as the transmitter for the core's channelized input.

## Interface
- WORDS, 2, number of 16-bit data words per candidate; 1 to 8.
- RESULT_DELAY, 2, cycles from the last data-beat handshake to the cycle in which hit_in is valid; at least 1; equals 2 for the hash core.
- clk  input  1  clock; all logic on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle pulse; honored only in IDLE.
- start_value  input  WORDS*16  first candidate, latched when start is taken.
- stop  input  1  abort request; latched, honored at the next candidate boundary.
- out_valid  output  1  stream beat valid.
- out_channel  output  1  1 = management beat, 0 = data beat.
- out_data  output  16  beat payload.
- out_ready  input  1  sink accepts the beat; tie to 1 for the core.
- hit_in  input  1  core success flag.
- busy  output  1  FSM is not in IDLE.
- done  output  1  one-cycle pulse when a run ends.
- found  output  1  last run ended on a hit; held until the next start.
- found_data  output  WORDS*16  candidate that hit; held until the next start.

## Operation
- States: IDLE, MGMT, DATA, WAIT.
- IDLE:
  - On start: latch cand = start_value, clear found, found_data and stop_req, then go to MGMT.
- MGMT:
  - Drive out_valid=1, out_channel=1, out_data=0.
  - On handshake (out_valid & out_ready): word index = 0, go to DATA.
- DATA:
  - Drive out_valid=1, out_channel=0, out_data = word[idx] of cand, most-significant word first (idx 0 = cand[WORDS*16-1 -: 16]).
  - Each handshake advances idx.
  - The handshake on idx = WORDS-1 goes to WAIT with wcnt = 1.
- WAIT:
  - out_valid=0. wcnt increments each cycle.
  - In the cycle where wcnt == RESULT_DELAY, sample hit_in and end the candidate:
    - hit_in=1: found=1, found_data=cand, done pulse, go to IDLE.
    - Else if cand is all ones, or stop_req=1: done pulse with found=0, go to IDLE.
    - Else: cand = cand + 1, go to MGMT.
- hit_in is ignored outside the sampling cycle. The core can assert it spuriously mid-sequence.
- Stream rules:
  - Once out_valid is asserted, out_channel and out_data stay stable until the handshake.
  - out_valid is never withdrawn without a handshake.
- stop:
  - A stop pulse in any non-IDLE state sets stop_req. It never truncates a beat or a candidate.
  - stop in IDLE is ignored.
- start while busy is ignored.
- Candidate arithmetic is unsigned, WORDS*16 bits. There is no wrap past all ones: that candidate is the last one tried.

## Timing
- Reset values:
  - out_valid=0, out_channel=0, out_data=0.
  - busy=0, done=0, found=0, found_data=0.
  - State IDLE, cand=0, idx=0, wcnt=0, stop_req=0.
- All outputs are registered; no combinational path from inputs to outputs.
- start in cycle 0 → MGMT beat presented in cycle 1, busy=1 from cycle 1.
- With out_ready tied to 1, each candidate takes 1 + WORDS + RESULT_DELAY cycles, back to back:
  - 1 MGMT cycle.
  - WORDS DATA cycles.
  - RESULT_DELAY WAIT cycles.
- The next MGMT beat starts the cycle after the sampling cycle. This guarantees the core state is not cleared before its flag is sampled.
- done pulses in the cycle after the sampling cycle, together with busy=0 and final found/found_data.
- out_ready low stalls in place for any number of cycles; the WAIT timing counts from the actual last handshake.
- Reset asserted mid-run returns immediately to the reset values. A partially sent candidate is abandoned; the next run's MGMT beat re-clears the core.

## Test plan
- Core with R4=16'h3412, R6=16'h1234, WORDS=1, ready=1, start_value=16'h1200:
  - Exactly 0x35 candidates are sent.
  - done pulses with found=1, found_data=16'h1234.
  - Each candidate is 4 cycles: MGMT beat with data 0, then data beat.
- WORDS=2, start_value=32'hFFFF_FFFE, core never hits:
  - Beats sent: FFFF, FFFE, then FFFF, FFFF, each pair preceded by a MGMT beat.
  - done pulses with found=0; nothing after.
- Random out_ready (~50%) versus a scoreboard:
  - Beat sequence identical to the ready=1 run.
  - No data or channel change while valid and not ready.
  - Same found_data.
- hit_in forced high only in cycles other than the sampling cycle → never found; forced high in the sampling cycle of candidate 3 → found_data = start_value + 3.
- stop pulse mid DATA on candidate 5:
  - Candidate 5 completes and is checked.
  - done pulses with found=0; no candidate 6 beats.
  - start in the next cycle begins a new run.
- reset_n low during a DATA beat:
  - All outputs are 0 asynchronously.
  - After release, start → new MGMT beat 1 cycle later.
